pll_reconfig_ctrl: RTL and testbench



---
 rtl/pll_ctrl_pkg.sv | 30 +++
 rtl/pll_reconfig_ctrl_if.sv | 9 +
 rtl/sync2.sv | 14 +
 rtl/pll_reconfig_ctrl.sv | 119 +++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared types and raw rPLL preset table for the reconfiguration sequencer
package pll_ctrl_pkg;

    typedef enum logic [2:0] {RESET_HOLD, WAIT_LOCK, SETTLE, RUN, FAULT} state_t;

    typedef struct packed {
        logic [5:0] fbdsel;
        logic [5:0] idsel;
        logic [5:0] odsel;
    } preset_t;

    // CLKOUT from 27 MHz CLKIN: 0=27 1=54 2=74.25 3=81 4=108 5=135 6=148.5 7=216 MHz
    localparam preset_t PRESETS [0:7] = '{
        '{6'd63, 6'd63, 6'd48},
        '{6'd62, 6'd63, 6'd56},
        '{6'd53, 6'd60, 6'd56},
        '{6'd61, 6'd63, 6'd56},
        '{6'd60, 6'd63, 6'd60},
        '{6'd59, 6'd63, 6'd60},
        '{6'd53, 6'd62, 6'd60},
        '{6'd56, 6'd63, 6'd62}
    };

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// pll_reconfig_ctrl_if: preset-select request handshake between UI logic and the sequencer
interface pll_reconfig_ctrl_if;
    logic       req_valid;
    logic [2:0] req_sel;
    logic       req_ready;

    modport master (output req_valid, req_sel, input req_ready);
    modport slave (input req_valid, req_sel, output req_ready);
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with synchronous reset to 0
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;

    always_ff @(posedge clk) begin
        if (rst) {q, m} <= 2'b00;
        else {q, m} <= {m, d};
    end
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequences rPLL divider presets through reset, lock wait and settle,
// retrying on lock timeout and reporting clock-good status.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int         RESET_CYCLES  = 16,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         SETTLE_CYCLES = 256,
    parameter int         MAX_RETRY     = 3,
    parameter logic [2:0] DEFAULT_SEL   = 3'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    pll_reconfig_ctrl_if.slave        req,
    input  logic                      pll_lock,
    output logic                      pll_reset,
    output logic [5:0]                fbdsel,
    output logic [5:0]                idsel,
    output logic [5:0]                odsel,
    output logic                      clk_ok,
    output logic                      busy,
    output logic                      fault,
    output logic                      lock_lost,
    output logic [2:0]                cur_sel
);
    localparam int CW = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES) + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    preset_t       codes;
    logic          lock_s;

    sync2 u_lock_sync (.clk(clk), .rst(rst), .d(pll_lock), .q(lock_s));

    assign {fbdsel, idsel, odsel} = codes;

    // One counter serves each timed state; it stops at the state's limit minus one
    always_ff @(posedge clk) begin
        lock_lost <= 1'b0;
        if (rst) begin
            state         <= RESET_HOLD;
            cnt           <= '0;
            retry         <= '0;
            pll_reset     <= 1'b1;
            codes         <= PRESETS[DEFAULT_SEL];
            cur_sel       <= DEFAULT_SEL;
            busy          <= 1'b1;
            clk_ok        <= 1'b0;
            fault         <= 1'b0;
            req.req_ready <= 1'b0;
        end else begin
            case (state)
                RESET_HOLD: begin
                    if (cnt == CW'(RESET_CYCLES - 1)) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        cnt       <= '0;
                        retry     <= retry + 1'b1;
                        pll_reset <= 1'b1;
                        if (retry < RW'(MAX_RETRY - 1)) state <= RESET_HOLD;
                        else begin
                            state         <= FAULT;
                            fault         <= 1'b1;
                            busy          <= 1'b0;
                            req.req_ready <= 1'b1;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                        state         <= RUN;
                        clk_ok        <= 1'b1;
                        busy          <= 1'b0;
                        req.req_ready <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                RUN: begin
                    if (!lock_s) begin
                        state         <= RESET_HOLD;
                        cnt           <= '0;
                        retry         <= '0;
                        lock_lost     <= 1'b1;
                        clk_ok        <= 1'b0;
                        pll_reset     <= 1'b1;
                        busy          <= 1'b1;
                        req.req_ready <= 1'b0;
                    end
                end
                default: ;
            endcase
            // An accepted request overrides any transition above; lock_lost still pulses
            if (req.req_valid && req.req_ready) begin
                state         <= RESET_HOLD;
                cnt           <= '0;
                retry         <= '0;
                codes         <= PRESETS[req.req_sel];
                cur_sel       <= req.req_sel;
                pll_reset     <= 1'b1;
                clk_ok        <= 1'b0;
                busy          <= 1'b1;
                fault         <= 1'b0;
                req.req_ready <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: randomized scenarios checked against a timing model of the sequencer
module tb_pll_reconfig_ctrl;
    import pll_ctrl_pkg::*;

    localparam int R = 4;
    localparam int T = 100;
    localparam int S = 8;
    localparam int M = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset, clk_ok, busy, fault, lock_lost;
    logic [5:0] fbdsel, idsel, odsel;
    logic [2:0] cur_sel;
    logic [17:0] prev_codes = '0;
    bit         mon_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_sel = 0;

    pll_reconfig_ctrl_if req_if ();

    pll_reconfig_ctrl #(
        .RESET_CYCLES(R), .LOCK_TIMEOUT(T), .SETTLE_CYCLES(S), .MAX_RETRY(M), .DEFAULT_SEL(3'd0)
    ) dut (
        .clk(clk), .rst(rst), .req(req_if), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .fbdsel(fbdsel), .idsel(idsel), .odsel(odsel), .clk_ok(clk_ok), .busy(busy),
        .fault(fault), .lock_lost(lock_lost), .cur_sel(cur_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int code_of(input int s);
        return int'(PRESETS[3'(s)]);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic measure_reset(input logic lvl, output int n);
        n = 0;
        while (pll_reset === lvl && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_state();
        check("rst_pll_reset", int'(pll_reset), 1);
        check("rst_cur_sel", int'(cur_sel), 0);
        check("rst_codes", int'({fbdsel, idsel, odsel}), code_of(0));
        check("rst_busy", int'(busy), 1);
        check("rst_clk_ok", int'(clk_ok), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_lock_lost", int'(lock_lost), 0);
        check("rst_ready", int'(req_if.req_ready), 0);
    endtask

    // Entered on the first sample with pll_reset high; lock is raised lock_at samples after
    // pll_reset falls, optionally glitched low for 3 samples starting glitch samples later.
    task automatic run_seq(input int sel, input int lock_at, input int glitch);
        int n;
        check("seq_cur_sel", int'(cur_sel), sel);
        check("seq_codes", int'({fbdsel, idsel, odsel}), code_of(sel));
        check("seq_busy", int'(busy), 1);
        check("seq_ready", int'(req_if.req_ready), 0);
        check("seq_clk_ok", int'(clk_ok), 0);
        measure_reset(1'b1, n);
        check("reset_len", n, R);
        check("seq_lock_lost", int'(lock_lost), 0);
        tick(lock_at);
        pll_lock = 1'b1;
        if (glitch > 0) begin
            tick(glitch);
            pll_lock = 1'b0;
            tick(3);
            pll_lock = 1'b1;
        end
        n = 0;
        while (!clk_ok && n < S + 20) begin
            tick();
            n++;
        end
        check("lock_to_clk_ok", n, S + 3);
        check("run_ready", int'(req_if.req_ready), 1);
        check("run_busy", int'(busy), 0);
        check("run_pll_reset", int'(pll_reset), 0);
    endtask

    task automatic request(input int sel, input int exp_lost);
        check("req_ready_hi", int'(req_if.req_ready), 1);
        req_if.req_valid = 1'b1;
        req_if.req_sel = 3'(sel);
        tick();
        req_if.req_valid = 1'b0;
        pll_lock = 1'b0;
        exp_sel = sel;
        check("req_lock_lost", int'(lock_lost), exp_lost);
        check("req_fault", int'(fault), 0);
    endtask

    task automatic drop_in_run(input int lock_at);
        pll_lock = 1'b0;
        tick(2);
        check("drop_clk_ok_held", int'(clk_ok), 1);
        check("drop_lost_early", int'(lock_lost), 0);
        tick();
        check("drop_clk_ok", int'(clk_ok), 0);
        check("drop_lost", int'(lock_lost), 1);
        run_seq(exp_sel, lock_at, 0);
    endtask

    task automatic simul(input int sel, input int lock_at);
        pll_lock = 1'b0;
        tick(2);
        request(sel, 1);
        run_seq(sel, lock_at, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && {fbdsel, idsel, odsel} != prev_codes)
            check("codes_only_with_reset", int'(pll_reset), 1);
        prev_codes = {fbdsel, idsel, odsel};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, act, sel, la, gl;
        req_if.req_valid = 1'b0;
        req_if.req_sel = 3'd0;
        tick(3);
        check_reset_state();
        mon_en = 1'b1;
        rst = 1'b0;
        run_seq(0, 10, 0);

        request(5, 0);
        run_seq(5, 7, 0);

        request(2, 0);
        run_seq(2, 3, 2);

        request(2, 0);
        run_seq(2, 0, S);

        drop_in_run(5);
        simul(6, 4);

        request(1, 0);
        measure_reset(1'b1, n);
        check("to_reset_len1", n, R);
        measure_reset(1'b0, n);
        check("to_wait_len1", n, T);
        measure_reset(1'b1, n);
        check("to_reset_len2", n, R);
        measure_reset(1'b0, n);
        check("to_wait_len2", n, T);
        check("fault_set", int'(fault), 1);
        check("fault_busy", int'(busy), 0);
        check("fault_ready", int'(req_if.req_ready), 1);
        check("fault_clk_ok", int'(clk_ok), 0);
        tick(20);
        check("fault_sticky", int'(fault), 1);
        check("fault_pll_reset", int'(pll_reset), 1);
        request(7, 0);
        run_seq(7, 12, 0);

        request(3, 0);
        measure_reset(1'b1, n);
        check("mid_reset_len", n, R);
        tick(5);
        rst = 1'b1;
        tick();
        check_reset_state();
        rst = 1'b0;
        exp_sel = 0;
        run_seq(0, 6, 0);

        for (int i = 0; i < 16; i++) begin
            act = int'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 7));
            la = int'($urandom_range(0, 30));
            gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, S)) : 0;
            if (act == 0) begin
                request(sel, 0);
                run_seq(sel, la, gl);
            end else if (act == 1) drop_in_run(la);
            else simul(sel, la);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
